// File: rtl/fir_block_serializer.sv
// rtl/fir_block_serializer.sv - two-entry block buffer re-emitting L-lane FIR output blocks as a serial stream
// Optional macro FIR_SER_INDEX_EN adds out_index, the running index of the sample on out_data.
module fir_block_serializer #(
  parameter int OUTP_WIDTH = 16,
  parameter int L          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [L*OUTP_WIDTH-1:0]   blk_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUTP_WIDTH-1:0]     out_data,
`ifdef FIR_SER_INDEX_EN
  output logic [31:0]               out_index,
`endif
  output logic                      out_last
);

  localparam int LW = $clog2(L);
  localparam logic [LW-1:0] LAST_LANE = LW'(L - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [L*OUTP_WIDTH-1:0] r_buf [2];
  logic [LW-1:0]           r_lane;
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;

  logic                    w_push;
  logic                    w_xfer;
  logic                    w_pop;
  logic [L*OUTP_WIDTH-1:0] w_rd_blk;

  // Handshake outputs decode registered state only, so out_ready never reaches blk_ready.
  assign blk_ready = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = blk_valid & blk_ready;
  assign w_xfer    = out_valid & out_ready;
  assign w_pop     = w_xfer & (r_lane == LAST_LANE);
  assign w_rd_blk  = r_buf[r_rd_ptr];
  assign out_data  = out_valid ? w_rd_blk[r_lane*OUTP_WIDTH +: OUTP_WIDTH] : '0;
  assign out_last  = out_valid & (r_lane == LAST_LANE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_lane   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= blk_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_lane   <= '0;
      end else if (w_xfer) begin
        r_lane <= r_lane + 1'b1;
      end
      case (r_state)
        EMPTY: if (w_push) r_state <= ONE;
        ONE: begin
          if (w_push && !w_pop)      r_state <= FULL;
          else if (!w_push && w_pop) r_state <= EMPTY;
        end
        FULL:    if (w_pop) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef FIR_SER_INDEX_EN
  logic [31:0] r_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_index <= '0;
    else if (w_xfer) r_index <= r_index + 32'd1;
  end

  assign out_index = r_index;
`endif

endmodule

// File: tb/tb_fir_block_serializer.sv
// tb/tb_fir_block_serializer.sv - queue-model bench for fir_block_serializer with directed and random traffic
module tb_fir_block_serializer;
  localparam int W  = 16;
  localparam int L  = 3;
  localparam int BW = L * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [BW-1:0] blk_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
`ifdef FIR_SER_INDEX_EN
  logic [31:0]   out_index;
`endif

  fir_block_serializer #(.OUTP_WIDTH(W), .L(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data(blk_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef FIR_SER_INDEX_EN
    .out_index(out_index),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [BW-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    return {c, b, a};
  endfunction

  // Model: FIFO of accepted blocks plus position of the sample being offered.
  logic [BW-1:0] mq [$];
  int            pos = 0;
  logic [31:0]   m_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    logic do_push, do_xfer;
    if (!rst_n) begin
      mq.delete();
      pos   = 0;
      m_idx = 0;
    end else begin
      do_push = blk_valid && (mq.size() < 2);
      do_xfer = (mq.size() > 0) && out_ready;
      if (do_xfer) begin
        m_idx = m_idx + 32'd1;
        if (pos == L - 1) begin
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (do_push) mq.push_back(blk_data);
    end
  end

  always @(negedge clk) begin
    logic [BW-1:0] hb;
    logic [W-1:0]  exp_d;
    exp_d = '0;
    if (mq.size() > 0) begin
      hb    = mq[0];
      exp_d = hb[pos*W +: W];
    end
    check("blk_ready", blk_ready, mq.size() < 2);
    check("out_valid", out_valid, mq.size() > 0);
    check("out_data", out_data, exp_d);
    check("out_last", out_last, (mq.size() > 0) && (pos == L - 1));
`ifdef FIR_SER_INDEX_EN
    if (mq.size() > 0) check("out_index", out_index, m_idx);
`endif
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, out_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp_seq [6];
    logic [BW-1:0] b1, b2;

    repeat (2) @(negedge clk);
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;

    // Single block
    blk_valid = 1'b1; blk_data = mk(16'h0001, 16'hFFFE, 16'h7FFF); out_ready = 1'b1;
    @(negedge clk); blk_valid = 1'b0;
    check("single_s0", out_data, 16'h0001); check("single_l0", out_last, 1'b0);
    @(negedge clk);
    check("single_s1", out_data, 16'hFFFE); check("single_l1", out_last, 1'b0);
    @(negedge clk);
    check("single_s2", out_data, 16'h7FFF); check("single_l2", out_last, 1'b1);
    @(negedge clk);
    check("single_empty", out_valid, 1'b0);

    // Fill to FULL, then release
    b1 = mk(16'h0A01, 16'h0A02, 16'h0A03);
    b2 = mk(16'h0B01, 16'h0B02, 16'h0B03);
    exp_seq = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0B01, 16'h0B02, 16'h0B03};
    out_ready = 1'b0; blk_valid = 1'b1; blk_data = b1;
    @(negedge clk); blk_data = b2;
    @(negedge clk); check("full_ready0", blk_ready, 1'b0);
    blk_data = mk(16'h0C01, 16'h0C02, 16'h0C03);
    repeat (3) begin
      @(negedge clk); check("full_hold", blk_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("full_order", out_data, exp_seq[i]);
      if (i == 4) blk_valid = 1'b0;
      @(negedge clk);
    end
    drain("full_drain");

    // Stall on lane 1
    blk_valid = 1'b1; blk_data = mk(16'h1111, 16'h2222, 16'h3333); out_ready = 1'b0;
    @(negedge clk); blk_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_data", out_data, 16'h2222);
      check("stall_last", out_last, 1'b0);
      @(negedge clk);
    end
    check("stall_data_end", out_data, 16'h2222);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_lane2", out_data, 16'h3333); check("stall_last2", out_last, 1'b1);
    @(negedge clk);
    check("stall_empty", out_valid, 1'b0);

    // Push and pop in the same cycle
    blk_valid = 1'b1; blk_data = mk(16'h4001, 16'h4002, 16'h4003); out_ready = 1'b1;
    @(negedge clk); blk_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); check("pp_lane2", out_data, 16'h4003);
    blk_valid = 1'b1; blk_data = mk(16'h5001, 16'h5002, 16'h5003);
    @(negedge clk); blk_valid = 1'b0;
    check("pp_new_lane0", out_data, 16'h5001);
    check("pp_ready", blk_ready, 1'b1);
    drain("pp_drain");

    // Reset in the middle of a block
    blk_valid = 1'b1; blk_data = mk(16'h6001, 16'h6002, 16'h6003); out_ready = 1'b1;
    @(negedge clk); blk_valid = 1'b0;
    @(negedge clk); check("mid_lane1", out_data, 16'h6002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", blk_ready, 1'b1);
    check("mid_rst_data", out_data, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); check("mid_no_stale", out_valid, 1'b0);
    end

`ifdef FIR_SER_INDEX_EN
    blk_valid = 1'b1; blk_data = mk(16'h7001, 16'h7002, 16'h7003); out_ready = 1'b1;
    @(negedge clk); blk_data = mk(16'h7101, 16'h7102, 16'h7103);
    check("idx_0", out_index, 32'd0);
    @(negedge clk); blk_valid = 1'b0;
    check("idx_1", out_index, 32'd1);
    for (int i = 2; i < 6; i++) begin
      @(negedge clk); check("idx_n", out_index, 32'(i));
    end
    drain("idx_drain");
    dut.r_index = 32'hFFFF_FFFF;
    m_idx = 32'hFFFF_FFFF;
    blk_valid = 1'b1; blk_data = mk(16'h7201, 16'h7202, 16'h7203);
    @(negedge clk); blk_valid = 1'b0;
    check("idx_max", out_index, 32'hFFFF_FFFF);
    @(negedge clk);
    check("idx_wrap", out_index, 32'd0);
    drain("idx_drain2");
`endif

    // Random traffic, checked by the model
    repeat (3000) begin
      blk_valid = ($urandom % 100) < 40;
      blk_data  = BW'({$urandom(), $urandom()});
      out_ready = ($urandom % 100) < 70;
      @(negedge clk);
    end
    blk_valid = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
